// File: rtl/ex_stage_if.sv
// Signal bundle between decode, hazard unit, forwarding sources and the execute stage.
// The slave modport is the execute stage's view; master is the driver's view.
interface ex_stage_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            stall_e;
  logic            flush_e;
  logic            valid_d;
  logic [XLEN-1:0] rd1_d;
  logic [XLEN-1:0] rd2_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] imm_ext_d;
  logic [4:0]      rs1_d;
  logic [4:0]      rs2_d;
  logic [4:0]      rd_d;
  logic [2:0]      alu_control_d;
  logic            alu_src_d;
  logic            reg_write_d;
  logic            mem_write_d;
  logic            jump_d;
  logic            branch_d;
  logic [1:0]      result_src_d;
  logic [1:0]      forward_a_e;
  logic [1:0]      forward_b_e;
  logic [XLEN-1:0] alu_result_m;
  logic [XLEN-1:0] result_w;

  logic [XLEN-1:0] alu_result_e;
  logic [XLEN-1:0] write_data_e;
  logic [XLEN-1:0] pc_target_e;
  logic            pc_src_e;
  logic            zero_e;
  logic [4:0]      rd_e;
  logic [4:0]      rs1_e;
  logic [4:0]      rs2_e;
  logic            reg_write_e;
  logic            mem_write_e;
  logic [1:0]      result_src_e;

  modport slave (
    input  stall_e, flush_e, valid_d, rd1_d, rd2_d, pc_d, imm_ext_d,
           rs1_d, rs2_d, rd_d, alu_control_d, alu_src_d, reg_write_d,
           mem_write_d, jump_d, branch_d, result_src_d, forward_a_e,
           forward_b_e, alu_result_m, result_w,
    output alu_result_e, write_data_e, pc_target_e, pc_src_e, zero_e,
           rd_e, rs1_e, rs2_e, reg_write_e, mem_write_e, result_src_e
  );

  modport master (
    output stall_e, flush_e, valid_d, rd1_d, rd2_d, pc_d, imm_ext_d,
           rs1_d, rs2_d, rd_d, alu_control_d, alu_src_d, reg_write_d,
           mem_write_d, jump_d, branch_d, result_src_d, forward_a_e,
           forward_b_e, alu_result_m, result_w,
    input  alu_result_e, write_data_e, pc_target_e, pc_src_e, zero_e,
           rd_e, rs1_e, rs2_e, reg_write_e, mem_write_e, result_src_e
  );
endinterface

// File: rtl/ex_stage.sv
// RV32I execute stage: ID/EX pipeline register, operand forwarding, ALU,
// branch target and redirect decision. One cycle from decode inputs to EX outputs.
module ex_stage #(
  parameter int unsigned XLEN = 32
) (
  input logic         clk,
  input logic         reset,
  ex_stage_if.slave   bus
);

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      alu_control;
    logic            alu_src;
    logic            reg_write;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic [1:0]      result_src;
  } idex_t;

  idex_t idex_q, idex_d;

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] write_data;
  logic [XLEN-1:0] alu_result;
  logic            zero;

  // Flush beats stall; an all-zero bubble decodes as an add of zeros.
  always_comb begin
    idex_d = idex_q;
    if (bus.flush_e) begin
      idex_d = '0;
    end else if (!bus.stall_e) begin
      idex_d.valid       = bus.valid_d;
      idex_d.rd1         = bus.rd1_d;
      idex_d.rd2         = bus.rd2_d;
      idex_d.pc          = bus.pc_d;
      idex_d.imm         = bus.imm_ext_d;
      idex_d.rs1         = bus.rs1_d;
      idex_d.rs2         = bus.rs2_d;
      idex_d.rd          = bus.rd_d;
      idex_d.alu_control = bus.alu_control_d;
      idex_d.alu_src     = bus.alu_src_d;
      idex_d.reg_write   = bus.reg_write_d;
      idex_d.mem_write   = bus.mem_write_d;
      idex_d.jump        = bus.jump_d;
      idex_d.branch      = bus.branch_d;
      idex_d.result_src  = bus.result_src_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  always_comb begin
    src_a      = idex_q.rd1;
    write_data = idex_q.rd2;
    case (bus.forward_a_e)
      2'b10:   src_a = bus.alu_result_m;
      2'b01:   src_a = bus.result_w;
      default: src_a = idex_q.rd1;
    endcase
    case (bus.forward_b_e)
      2'b10:   write_data = bus.alu_result_m;
      2'b01:   write_data = bus.result_w;
      default: write_data = idex_q.rd2;
    endcase
    src_b = idex_q.alu_src ? idex_q.imm : write_data;
  end

  always_comb begin
    alu_result = '0;
    case (idex_q.alu_control)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_result = '0;
    endcase
    zero = (alu_result == '0);
  end

  assign bus.alu_result_e = alu_result;
  assign bus.write_data_e = write_data;
  assign bus.zero_e       = zero;
  assign bus.pc_target_e  = idex_q.pc + idex_q.imm;
  assign bus.pc_src_e     = idex_q.valid & (idex_q.jump | (idex_q.branch & zero));
  assign bus.reg_write_e  = idex_q.reg_write & idex_q.valid;
  assign bus.mem_write_e  = idex_q.mem_write & idex_q.valid;
  assign bus.rd_e         = idex_q.rd;
  assign bus.rs1_e        = idex_q.rs1;
  assign bus.rs2_e        = idex_q.rs2;
  assign bus.result_src_e = idex_q.result_src;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: each driven cycle pushes the expected EX outputs,
// which are popped and compared after the following rising edge.
module tb_ex_stage;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      alu_control;
    logic            alu_src;
    logic            reg_write;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic [1:0]      result_src;
  } dec_t;

  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] pc_target;
    logic            pc_src;
    logic            zero;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            reg_write;
    logic            mem_write;
    logic [1:0]      result_src;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  dec_t ex_model = '0;
  exp_t sb[$];

  ex_stage_if #(.XLEN(XLEN)) bus ();

  ex_stage #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic exp_t model_out(input dec_t d, input logic [1:0] fa, input logic [1:0] fb,
                                     input logic [XLEN-1:0] m, input logic [XLEN-1:0] w);
    exp_t e;
    logic [XLEN-1:0] a, b, wd, r;
    a  = (fa == 2'b10) ? m : (fa == 2'b01) ? w : d.rd1;
    wd = (fb == 2'b10) ? m : (fb == 2'b01) ? w : d.rd2;
    b  = d.alu_src ? d.imm : wd;
    case (d.alu_control)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b101:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    e.alu_result = r;
    e.write_data = wd;
    e.pc_target  = d.pc + d.imm;
    e.zero       = (r == 32'd0);
    e.pc_src     = d.valid & (d.jump | (d.branch & (r == 32'd0)));
    e.rd         = d.rd;
    e.rs1        = d.rs1;
    e.rs2        = d.rs2;
    e.reg_write  = d.reg_write & d.valid;
    e.mem_write  = d.mem_write & d.valid;
    e.result_src = d.result_src;
    return e;
  endfunction

  task automatic step(input dec_t d, input logic rst, input logic fl, input logic st,
                      input logic [1:0] fa, input logic [1:0] fb,
                      input logic [XLEN-1:0] m, input logic [XLEN-1:0] w);
    exp_t e;
    @(negedge clk);
    reset             = rst;
    bus.flush_e       = fl;
    bus.stall_e       = st;
    bus.valid_d       = d.valid;
    bus.rd1_d         = d.rd1;
    bus.rd2_d         = d.rd2;
    bus.pc_d          = d.pc;
    bus.imm_ext_d     = d.imm;
    bus.rs1_d         = d.rs1;
    bus.rs2_d         = d.rs2;
    bus.rd_d          = d.rd;
    bus.alu_control_d = d.alu_control;
    bus.alu_src_d     = d.alu_src;
    bus.reg_write_d   = d.reg_write;
    bus.mem_write_d   = d.mem_write;
    bus.jump_d        = d.jump;
    bus.branch_d      = d.branch;
    bus.result_src_d  = d.result_src;
    bus.forward_a_e   = fa;
    bus.forward_b_e   = fb;
    bus.alu_result_m  = m;
    bus.result_w      = w;
    if (rst || fl) ex_model = '0;
    else if (!st)  ex_model = d;
    sb.push_back(model_out(ex_model, fa, fb, m, w));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("alu_result_e", bus.alu_result_e, e.alu_result);
    check("write_data_e", bus.write_data_e, e.write_data);
    check("pc_target_e",  bus.pc_target_e,  e.pc_target);
    check("pc_src_e",     {31'd0, bus.pc_src_e},    {31'd0, e.pc_src});
    check("zero_e",       {31'd0, bus.zero_e},      {31'd0, e.zero});
    check("rd_e",         {27'd0, bus.rd_e},        {27'd0, e.rd});
    check("rs1_e",        {27'd0, bus.rs1_e},       {27'd0, e.rs1});
    check("rs2_e",        {27'd0, bus.rs2_e},       {27'd0, e.rs2});
    check("reg_write_e",  {31'd0, bus.reg_write_e}, {31'd0, e.reg_write});
    check("mem_write_e",  {31'd0, bus.mem_write_e}, {31'd0, e.mem_write});
    check("result_src_e", {30'd0, bus.result_src_e}, {30'd0, e.result_src});
  endtask

  // Shorthand for an ALU instruction with register or immediate operand B.
  function automatic dec_t alu_op(input logic [2:0] ctl, input logic [XLEN-1:0] a,
                                  input logic [XLEN-1:0] b, input logic src_imm);
    dec_t d = '0;
    d.valid       = 1'b1;
    d.rd1         = a;
    d.rd2         = src_imm ? 32'd0 : b;
    d.imm         = src_imm ? b : 32'h0000_0004;
    d.pc          = 32'h0000_0040;
    d.rs1         = 5'd1;
    d.rs2         = 5'd2;
    d.rd          = 5'd3;
    d.alu_control = ctl;
    d.alu_src     = src_imm;
    d.reg_write   = 1'b1;
    d.result_src  = 2'b01;
    return d;
  endfunction

  initial begin
    dec_t z, d, a_ins, b_ins;
    z = '0;

    // Reset for two cycles, then an idle cycle
    step(z, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
    step(z, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
    step(z, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
    check("idle_zero", {31'd0, bus.zero_e}, 32'd1);

    step(alu_op(3'b001, 32'd7, 32'd9, 1'b0), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
    check("sub_7_9", bus.alu_result_e, 32'hFFFF_FFFE);
    step(alu_op(3'b101, 32'h8000_0000, 32'd1, 1'b0), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
    check("slt_neg", bus.alu_result_e, 32'd1);
    step(alu_op(3'b000, 32'h8000_0000, 32'd1, 1'b0), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
    check("add_msb", bus.alu_result_e, 32'h8000_0001);
    step(alu_op(3'b000, 32'hFFFF_FFFF, 32'd1, 1'b0), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
    check("add_wrap_zero", {31'd0, bus.zero_e}, 32'd1);
    for (int unsigned c = 4; c < 8; c++) begin
      step(alu_op(c[2:0], 32'h0F0F_1234, 32'h00FF_0F0F, 1'b0), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
    end

    // Forwarding for operand A, then for B / write_data
    d = alu_op(3'b000, 32'h30, 32'h0, 1'b1);
    step(d, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 32'h10, 32'h20);
    check("fwd_a_m", bus.alu_result_e, 32'h10);
    step(d, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 32'h10, 32'h20);
    check("fwd_a_w", bus.alu_result_e, 32'h20);
    step(d, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 32'h10, 32'h20);
    check("fwd_a_reg", bus.alu_result_e, 32'h30);
    d = alu_op(3'b011, 32'h1, 32'h40, 1'b0);
    for (int unsigned f = 0; f < 4; f++) begin
      step(d, 1'b0, 1'b0, 1'b0, 2'b00, f[1:0], 32'h100, 32'h200);
    end

    // Taken branch, then the same branch flushed on its load edge
    d = alu_op(3'b001, 32'd5, 32'd5, 1'b0);
    d.branch = 1'b1; d.reg_write = 1'b0; d.pc = 32'h100; d.imm = 32'h20;
    step(d, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
    check("br_taken", {31'd0, bus.pc_src_e}, 32'd1);
    check("br_target", bus.pc_target_e, 32'h120);
    d.reg_write = 1'b1;
    step(d, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
    check("br_flushed", {30'd0, bus.pc_src_e, bus.reg_write_e}, 32'd0);

    // Stall holds A while B is presented; flush+stall bubbles; reset+stall clears
    a_ins = alu_op(3'b010, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
    a_ins.mem_write = 1'b1; a_ins.rd = 5'd9; a_ins.jump = 1'b1;
    b_ins = alu_op(3'b011, 32'h1234_0000, 32'h0000_5678, 1'b0);
    b_ins.rd = 5'd17;
    step(a_ins, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
    for (int unsigned i = 0; i < 3; i++) begin
      step(b_ins, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 32'h0, 32'h0);
    end
    check("stall_hold", bus.alu_result_e, 32'h0F00_0F00);
    step(b_ins, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 32'h0, 32'h0);
    check("flush_stall_rd", {27'd0, bus.rd_e}, 32'd0);
    step(a_ins, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
    step(b_ins, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 32'h0, 32'h0);
    check("reset_stall_pcsrc", {31'd0, bus.pc_src_e}, 32'd0);

    // Randomised mix of controls and hazards
    for (int unsigned i = 0; i < 40; i++) begin
      d = dec_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      if ((i % 5) == 0) d.rd2 = d.rd1;
      step(d, ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
           2'($urandom), 2'($urandom), $urandom, $urandom);
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
